// File: rtl/ysyx_041461_wb_trap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_041461_wb_trap_ctrl_pkg
//   Shared constants for the WB-stage trap/CSR controller: IF-stage redirect
//   codes, controller FSM states, machine-mode CSR addresses, trap cause
//   codes and mstatus bit positions.
//   Optional feature macro used by the importing files:
//   YSYX_041461_TRAP_INT_EN (enables the machine timer interrupt path).
// ---------------------------------------------------------------------------
package ysyx_041461_wb_trap_ctrl_pkg;

    // Redirect code presented to the IF-stage PC register
    typedef enum logic [1:0] {
        IFREG_NOP   = 2'b00,
        IFREG_MTVEC = 2'b01,
        IFREG_MEPC  = 2'b10
    } ifreg_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_PEND_TVEC = 2'b01,
        ST_PEND_EPC  = 2'b10
    } trap_state_e;

    // Machine-mode CSR map
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    // Trap cause codes (mcause[62:0])
    localparam logic [62:0] CAUSE_ECALL_M = 63'd11;
    localparam logic [62:0] CAUSE_BREAK   = 63'd3;
    localparam logic [62:0] CAUSE_MTI     = 63'd7;

    // mstatus / mie / mip bit positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MIE_MTIE       = 7;
    localparam int MIP_MTIP       = 7;

    // Only MIE, MPIE and MPP are software-writable in mstatus
    localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888;

    function automatic logic [63:0] mk_cause(input logic irq, input logic [62:0] code);
        return {irq, code};
    endfunction

endpackage

// File: rtl/ysyx_041461_csr_file.sv
// ---------------------------------------------------------------------------
// ysyx_041461_csr_file
//   Machine-mode CSR storage with legalised software writes, a combinational
//   read mux, and the trap-entry / mret side effects on mstatus/mepc/mcause.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     we/waddr/wdata    gated CSR write (already filtered by the controller)
//     trap_en/trap_pc/trap_cause  trap entry side effects
//     mret_en           mret side effects on mstatus
//     timer_irq         MTIP level, reflected in mip
//     raddr/rdata       combinational read port (pre-write value)
//     mtvec/mepc/mcause registered CSR values for the redirect path
//     mstatus_mie/mie_mtie  interrupt enable bits
//   Macro YSYX_041461_TRAP_INT_EN: when undefined, mie/mip read 0, mie writes
//   are dropped and mcause[63] can never be set.
// ---------------------------------------------------------------------------
module ysyx_041461_csr_file
    import ysyx_041461_wb_trap_ctrl_pkg::*;
#(
    parameter logic [63:0] RST_MTVEC   = 64'h0,
    parameter logic [63:0] RST_MSTATUS = 64'h0000_0000_0000_1800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [11:0] waddr,
    input  logic [63:0] wdata,
    input  logic        trap_en,
    input  logic [63:0] trap_pc,
    input  logic [63:0] trap_cause,
    input  logic        mret_en,
    input  logic        timer_irq,
    input  logic [11:0] raddr,
    output logic [63:0] rdata,
    output logic [63:0] mtvec,
    output logic [63:0] mepc,
    output logic [63:0] mcause,
    output logic        mstatus_mie,
    output logic        mie_mtie
);

    logic [63:0] mstatus_q, mstatus_d;
    logic [63:0] mie_q, mie_d;
    logic [63:0] mtvec_q, mtvec_d;
    logic [63:0] mscratch_q, mscratch_d;
    logic [63:0] mepc_q, mepc_d;
    logic [63:0] mcause_q, mcause_d;
    logic [63:0] mip_val;

`ifdef YSYX_041461_TRAP_INT_EN
    localparam logic [63:0] MCAUSE_WMASK = '1;
    always_comb begin
        mip_val           = '0;
        mip_val[MIP_MTIP] = timer_irq;
    end
`else
    // Without the interrupt path, mcause[63] is never set by any route
    localparam logic [63:0] MCAUSE_WMASK = 64'h7FFF_FFFF_FFFF_FFFF;
    logic unused_timer_irq;
    assign unused_timer_irq = timer_irq;
    assign mip_val          = '0;
`endif

    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (trap_en) begin
            mepc_d                                 = trap_pc;
            mcause_d                               = trap_cause & MCAUSE_WMASK;
            mstatus_d[MSTATUS_MPIE]                = mstatus_q[MSTATUS_MIE];
            mstatus_d[MSTATUS_MIE]                 = 1'b0;
            mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        end else if (mret_en) begin
            mstatus_d[MSTATUS_MIE]                 = mstatus_q[MSTATUS_MPIE];
            mstatus_d[MSTATUS_MPIE]                = 1'b1;
            mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        end else if (we) begin
            unique case (waddr)
                CSR_MSTATUS:  mstatus_d  = (mstatus_q & ~MSTATUS_WMASK) | (wdata & MSTATUS_WMASK);
`ifdef YSYX_041461_TRAP_INT_EN
                CSR_MIE:      mie_d      = wdata;
`endif
                CSR_MTVEC:    mtvec_d    = {wdata[63:2], 1'b0, wdata[0]};
                CSR_MSCRATCH: mscratch_d = wdata;
                CSR_MEPC:     mepc_d     = {wdata[63:2], 2'b00};
                CSR_MCAUSE:   mcause_d   = wdata & MCAUSE_WMASK;
                default: ;  // mip is read-only; unknown addresses drop the write
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_q  <= RST_MSTATUS;
            mie_q      <= '0;
            mtvec_q    <= RST_MTVEC;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    // Pre-write read value; ID is stalled on a WB address match upstream
    always_comb begin
        rdata = '0;
        unique case (raddr)
            CSR_MSTATUS:  rdata = mstatus_q;
            CSR_MIE:      rdata = mie_q;
            CSR_MTVEC:    rdata = mtvec_q;
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MEPC:     rdata = mepc_q;
            CSR_MCAUSE:   rdata = mcause_q;
            CSR_MIP:      rdata = mip_val;
            default:      rdata = '0;
        endcase
    end

    assign mtvec       = mtvec_q;
    assign mepc        = mepc_q;
    assign mcause      = mcause_q;
    assign mstatus_mie = mstatus_q[MSTATUS_MIE];
    assign mie_mtie    = mie_q[MIE_MTIE];

endmodule

// File: rtl/ysyx_041461_wb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_041461_wb_trap_ctrl
//   WB-stage trap/CSR controller. Detects timer interrupt, ecall, ebreak and
//   mret on the WB instruction, updates the machine CSRs, and holds a
//   redirect request (ctrl/mtvec/mepc/cause) towards the IF-stage PC register
//   until it is consumed, flushing the pipeline meanwhile.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     wb_*                     WB instruction info and CSR write request
//     csr_raddr/csr_rdata      ID CSR read port (combinational)
//     timer_irq                MTIP level
//     ifreg_enable             PC register consumes the redirect this cycle
//     ifreg_ctrl/mtvec/mepc/cause  redirect request
//     wb_kill                  drop the WB register write (interrupt taken)
//     flush                    squash IF/ID/EX/MEM while a redirect pends
//   Macro YSYX_041461_TRAP_INT_EN enables the timer interrupt path; without it
//   timer_irq is ignored, ifreg_cause is 0 and wb_kill is 0.
// ---------------------------------------------------------------------------
module ysyx_041461_wb_trap_ctrl
    import ysyx_041461_wb_trap_ctrl_pkg::*;
#(
    parameter logic [63:0] RST_MTVEC   = 64'h0,
    parameter logic [63:0] RST_MSTATUS = 64'h0000_0000_0000_1800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [63:0] wb_pc,
    input  logic        wb_ecall,
    input  logic        wb_ebreak,
    input  logic        wb_mret,
    input  logic        wb_csr_we,
    input  logic [11:0] wb_csr_waddr,
    input  logic [63:0] wb_csr_wdata,
    input  logic [11:0] csr_raddr,
    output logic [63:0] csr_rdata,
    input  logic        timer_irq,
    input  logic        ifreg_enable,
    output logic [1:0]  ifreg_ctrl,
    output logic [63:0] ifreg_mtvec,
    output logic [63:0] ifreg_mepc,
    output logic [62:0] ifreg_cause,
    output logic        wb_kill,
    output logic        flush
);

    trap_state_e state_q, state_d;
    ifreg_ctrl_e ctrl_q, ctrl_d;
    logic        flush_q, flush_d;

    logic        trap_en, mret_en, csr_we_g, kill_c, irq_take;
    logic [63:0] trap_cause;
    logic [63:0] mcause;
    logic        mstatus_mie, mie_mtie;

    ysyx_041461_csr_file #(
        .RST_MTVEC   (RST_MTVEC),
        .RST_MSTATUS (RST_MSTATUS)
    ) u_csr (
        .clk         (clk),
        .rst         (rst),
        .we          (csr_we_g),
        .waddr       (wb_csr_waddr),
        .wdata       (wb_csr_wdata),
        .trap_en     (trap_en),
        .trap_pc     (wb_pc),
        .trap_cause  (trap_cause),
        .mret_en     (mret_en),
        .timer_irq   (timer_irq),
        .raddr       (csr_raddr),
        .rdata       (csr_rdata),
        .mtvec       (ifreg_mtvec),
        .mepc        (ifreg_mepc),
        .mcause      (mcause),
        .mstatus_mie (mstatus_mie),
        .mie_mtie    (mie_mtie)
    );

`ifdef YSYX_041461_TRAP_INT_EN
    assign irq_take    = mstatus_mie & mie_mtie & timer_irq;
    // Vectored-mode offset only meaningful for interrupts while redirecting
    assign ifreg_cause = (flush_q && mcause[63]) ? mcause[62:0] : '0;
    assign wb_kill     = kill_c;
`else
    logic unused_int;
    assign unused_int  = mstatus_mie ^ mie_mtie ^ timer_irq ^ kill_c ^ (^mcause);
    assign irq_take    = 1'b0;
    assign ifreg_cause = '0;
    assign wb_kill     = 1'b0;
`endif

    // Priority: interrupt > ecall > ebreak > mret > CSR write. A trapping
    // instruction's CSR write is dropped; nothing is sampled while pending.
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        flush_d    = flush_q;
        trap_en    = 1'b0;
        mret_en    = 1'b0;
        csr_we_g   = 1'b0;
        kill_c     = 1'b0;
        trap_cause = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (wb_valid) begin
                    if (irq_take) begin
                        trap_en    = 1'b1;
                        kill_c     = 1'b1;  // instruction re-executes after mret
                        trap_cause = mk_cause(1'b1, CAUSE_MTI);
                    end else if (wb_ecall) begin
                        trap_en    = 1'b1;
                        trap_cause = mk_cause(1'b0, CAUSE_ECALL_M);
                    end else if (wb_ebreak) begin
                        trap_en    = 1'b1;
                        trap_cause = mk_cause(1'b0, CAUSE_BREAK);
                    end else if (wb_mret) begin
                        mret_en = 1'b1;
                        state_d = ST_PEND_EPC;
                        ctrl_d  = IFREG_MEPC;
                        flush_d = 1'b1;
                    end else if (wb_csr_we) begin
                        csr_we_g = 1'b1;
                    end
                    if (trap_en) begin
                        state_d = ST_PEND_TVEC;
                        ctrl_d  = IFREG_MTVEC;
                        flush_d = 1'b1;
                    end
                end
            end
            ST_PEND_TVEC, ST_PEND_EPC: begin
                if (ifreg_enable) begin
                    state_d = ST_IDLE;
                    ctrl_d  = IFREG_NOP;
                    flush_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ctrl_d  = IFREG_NOP;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ctrl_q  <= IFREG_NOP;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            flush_q <= flush_d;
        end
    end

    assign ifreg_ctrl = ctrl_q;
    assign flush      = flush_q;

endmodule
